// File: rtl/lzs_pkg.sv
// rtl/lzs_pkg.sv - shared constants, state encoding and helpers for the LZS stream feeder
package lzs_pkg;

   localparam int WORD_W    = 16;
   localparam int BUF_W     = 64;
   localparam int LEFT_W    = 7;
   localparam int REFILL_TH = 48;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Decoder may ask for more bits than remain at the tail of a stream.
   function automatic logic [LEFT_W-1:0] sat_consume(input logic [3:0]        width,
                                                     input logic [LEFT_W-1:0] left);
      logic [LEFT_W-1:0] w;
      w = LEFT_W'(width);
      return (w > left) ? left : w;
   endfunction

endpackage

// File: rtl/lzs_stream_feeder_bit_buffer.sv
// rtl/lzs_stream_feeder_bit_buffer.sv - 64-bit left-aligned shift buffer with same-cycle consume and refill
module lzs_bit_buffer
   import lzs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [LEFT_W-1:0] consumed,
   input  logic              push,
   input  logic [WORD_W-1:0] word,
   output logic [BUF_W-1:0]  shreg,
   output logic [LEFT_W-1:0] left
);

   logic [BUF_W-1:0]  shreg_q, shreg_d;
   logic [LEFT_W-1:0] left_q, left_d;
   logic [LEFT_W-1:0] kept;
   logic [LEFT_W-1:0] ins_pos;

   always_comb begin
      shreg_d = shreg_q;
      left_d  = left_q;
      kept    = left_q - consumed;
      // New word lands directly behind the bits that survive this cycle's consume.
      ins_pos = LEFT_W'(REFILL_TH) - kept;
      if (ce) begin
         shreg_d = shreg_q << consumed;
         left_d  = kept;
         if (push) begin
            shreg_d = shreg_d | ({{(BUF_W-WORD_W){1'b0}}, word} << ins_pos);
            left_d  = kept + LEFT_W'(WORD_W);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         left_q  <= '0;
      end else begin
         shreg_q <= shreg_d;
         left_q  <= left_d;
      end
   end

   assign shreg = shreg_q;
   assign left  = left_q;

endmodule

// File: rtl/lzs_stream_feeder.sv
// rtl/lzs_stream_feeder.sv - feeds a FIFO of big-endian 16-bit words to a decoder as an MSB-first bit window
module lzs_stream_feeder
   import lzs_pkg::*;
#(
   parameter int IN_WIDTH  = 13,
   parameter int LZF_WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce_decode,
   input  logic                 start,
   input  logic [LZF_WIDTH-1:0] src_size,
   input  logic [WORD_W-1:0]    fi_data,
   input  logic                 fi_empty,
   output logic                 fi_rd,
   output logic                 stream_valid,
   output logic [IN_WIDTH-1:0]  stream_data,
   input  logic                 stream_ack,
   input  logic [3:0]           stream_width,
   output logic                 stream_empty,
   output logic                 done
);

   state_t               state_q, state_d;
   logic [LZF_WIDTH-1:0] words_rem_q, words_rem_d;
   logic                 odd_q, odd_d;
   logic                 empty_q, empty_d;
   logic                 done_q, done_d;

   logic [BUF_W-1:0]     shreg;
   logic [LEFT_W-1:0]    left;
   logic [LEFT_W-1:0]    consumed;
   logic [WORD_W-1:0]    word;
   logic                 last_word;

   lzs_bit_buffer u_buf (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce_decode),
      .consumed (consumed),
      .push     (fi_rd),
      .word     (word),
      .shreg    (shreg),
      .left     (left)
   );

   always_comb begin
      stream_valid = ((state_q == ST_RUN) && (left >= LEFT_W'(IN_WIDTH))) ||
                     ((state_q == ST_DRAIN) && (left != '0));
      stream_data  = shreg[BUF_W-1 -: IN_WIDTH];
      consumed     = (stream_valid && stream_ack) ? sat_consume(stream_width, left) : '0;
      fi_rd        = ce_decode && !rst && ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                     !fi_empty && (words_rem_q != '0) &&
                     ((left - consumed) <= LEFT_W'(REFILL_TH));
      // An odd byte count leaves a pad byte in the final word; it must reach the decoder as zeros.
      last_word    = (words_rem_q == LZF_WIDTH'(1));
      word         = (odd_q && last_word) ? {fi_data[WORD_W-1:8], 8'h00} : fi_data;
   end

   always_comb begin
      state_d     = state_q;
      words_rem_d = words_rem_q;
      odd_d       = odd_q;
      empty_d     = empty_q;
      done_d      = 1'b0;
      if (ce_decode) begin
         if (fi_rd) begin
            words_rem_d = words_rem_q - LZF_WIDTH'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d     = ST_FILL;
                  words_rem_d = (src_size >> 1) + LZF_WIDTH'(src_size[0]);
                  odd_d       = src_size[0];
                  empty_d     = 1'b0;
               end
            end
            ST_FILL: begin
               if ((left >= LEFT_W'(REFILL_TH)) || (words_rem_q == '0)) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (words_rem_q == '0) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (left == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  empty_d = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         words_rem_q <= '0;
         odd_q       <= 1'b0;
         empty_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         words_rem_q <= words_rem_d;
         odd_q       <= odd_d;
         empty_q     <= empty_d;
         done_q      <= done_d;
      end
   end

   assign stream_empty = empty_q;
   assign done         = done_q;

endmodule

// File: tb/tb_lzs_stream_feeder.sv
// tb/tb_lzs_stream_feeder.sv - scoreboard bench for lzs_stream_feeder
module tb_lzs_stream_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_decode;
   logic        start;
   logic [19:0] src_size;
   logic [15:0] fi_data;
   logic        fi_empty;
   logic        fi_rd;
   logic        stream_valid;
   logic [12:0] stream_data;
   logic        stream_ack;
   logic [3:0]  stream_width;
   logic        stream_empty;
   logic        done;

   always #5 clk = ~clk;

   lzs_stream_feeder #(.IN_WIDTH(13), .LZF_WIDTH(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce_decode    (ce_decode),
      .start        (start),
      .src_size     (src_size),
      .fi_data      (fi_data),
      .fi_empty     (fi_empty),
      .fi_rd        (fi_rd),
      .stream_valid (stream_valid),
      .stream_data  (stream_data),
      .stream_ack   (stream_ack),
      .stream_width (stream_width),
      .stream_empty (stream_empty),
      .done         (done)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] fifo_q[$];
   logic [15:0] pend_q[$];
   bit          exp_bits[$];
   int          pop_cnt   = 0;
   int          done_cnt  = 0;
   int          valid_cnt = 0;
   bit          freeze_chk = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] exp_window();
      logic [12:0] w;
      w = '0;
      for (int i = 0; i < 13; i++) begin
         if (i < exp_bits.size()) w[12-i] = exp_bits[i];
      end
      return w;
   endfunction

   task automatic refresh();
      fi_empty = (fifo_q.size() == 0);
      fi_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
   endtask

   // Show-ahead FIFO model
   always begin : fifo_model
      bit pop;
      @(posedge clk);
      pop = fi_rd;
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
   end

   // Monitor: every accepted window is compared with the expected bit stream
   always @(negedge clk) begin : monitor
      int n;
      if (!rst) begin
         if (fi_rd) pop_cnt++;
         if (done) done_cnt++;
         if (stream_valid) valid_cnt++;
         if (freeze_chk) begin
            check("frozen_window", 64'(stream_data), 64'(exp_window()));
            check("frozen_fi_rd", 64'(fi_rd), 64'd0);
         end
         if (ce_decode && stream_valid && stream_ack) begin
            check("window", 64'(stream_data), 64'(exp_window()));
            n = int'(stream_width);
            if (n > exp_bits.size()) n = exp_bits.size();
            repeat (n) void'(exp_bits.pop_front());
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load_stream(input logic [127:0] data, input int nbytes);
      logic [7:0]  hi, lo;
      logic [15:0] w;
      for (int i = 0; i < nbytes; i += 2) begin
         hi = data[127-8*i -: 8];
         lo = (i + 1 < nbytes) ? data[119-8*i -: 8] : 8'h00;
         w  = {hi, lo};
         pend_q.push_back((i + 1 < nbytes) ? w : {hi, 8'hDD});
         for (int k = 15; k >= 0; k--) exp_bits.push_back(w[k]);
      end
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n && pend_q.size() != 0; i++) fifo_q.push_back(pend_q.pop_front());
      refresh();
   endtask

   task automatic do_start(input int size);
      src_size = 20'(size);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (done_cnt < target && c < budget) begin
         tick();
         c++;
      end
      check("done_reached", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic wait_valid(input int budget);
      int c;
      c = 0;
      while (!stream_valid && c < budget) begin
         tick();
         c++;
      end
      check("valid_reached", 64'(stream_valid), 64'd1);
   endtask

   task automatic clear_counts();
      pop_cnt   = 0;
      done_cnt  = 0;
      valid_cnt = 0;
   endtask

   initial begin
      int c;
      rst = 1'b1; ce_decode = 1'b1; start = 1'b0; src_size = '0;
      stream_ack = 1'b0; stream_width = 4'd0;
      refresh();
      tick(2);
      check("rst_fi_rd", 64'(fi_rd), 64'd0);
      check("rst_valid", 64'(stream_valid), 64'd0);
      check("rst_data", 64'(stream_data), 64'd0);
      check("rst_empty", 64'(stream_empty), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_left", 64'(dut.u_buf.left_q), 64'd0);
      rst = 1'b0;
      tick();

      // Eight bytes, 13-bit acks every cycle; a stray start mid-run is ignored
      clear_counts();
      load_stream({64'h123456789ABCDEF0, 64'h0}, 8);
      feed(8);
      stream_ack = 1'b1; stream_width = 4'd13;
      do_start(8);
      wait_valid(50);
      check("t1_first_window", 64'(stream_data), 64'h0246);
      start = 1'b1; tick(); start = 1'b0;
      wait_done(1, 200);
      tick(2);
      check("t1_pops", 64'(pop_cnt), 64'd4);
      check("t1_done_pulses", 64'(done_cnt), 64'd1);
      check("t1_empty", 64'(stream_empty), 64'd1);
      check("t1_bits_left", 64'(exp_bits.size()), 64'd0);

      // Odd size: pad byte forced to zero
      clear_counts();
      load_stream({24'hAABBCC, 104'h0}, 3);
      feed(8);
      stream_width = 4'd8;
      do_start(3);
      wait_valid(50);
      check("t2_fill_buffer", dut.u_buf.shreg_q, 64'hAABBCC00_00000000);
      check("t2_fill_left", 64'(dut.u_buf.left_q), 64'd32);
      wait_done(1, 200);
      check("t2_pops", 64'(pop_cnt), 64'd2);
      check("t2_bits_left", 64'(exp_bits.size()), 64'd0);

      // Source stall with 9-bit acks
      clear_counts();
      load_stream({96'hF0E1D2C3B4A5968778695A4B, 32'h0}, 12);
      feed(3);
      stream_width = 4'd9;
      do_start(12);
      tick(20);
      check("t3_stall_left", 64'(dut.u_buf.left_q), 64'd12);
      check("t3_stall_valid", 64'(stream_valid), 64'd0);
      check("t3_stall_fi_rd", 64'(fi_rd), 64'd0);
      feed(8);
      wait_done(1, 300);
      check("t3_pops", 64'(pop_cnt), 64'd6);
      check("t3_bits_left", 64'(exp_bits.size()), 64'd0);

      // Consume and refill in the same cycle at left=48
      clear_counts();
      load_stream(128'h0123456789ABCDEFFEDCBA9876543210, 16);
      feed(3);
      stream_ack = 1'b0; stream_width = 4'd13;
      do_start(16);
      tick(10);
      check("t4_left48", 64'(dut.u_buf.left_q), 64'd48);
      feed(1);
      stream_ack = 1'b1;
      tick();
      check("t4_left51", 64'(dut.u_buf.left_q), 64'd51);
      check("t4_word_offset35", 64'(dut.u_buf.shreg_q[28:13]), 64'hCDEF);
      feed(8);
      wait_done(1, 300);
      check("t4_pops", 64'(pop_cnt), 64'd8);
      check("t4_bits_left", 64'(exp_bits.size()), 64'd0);

      // Reset mid-stream, then a fresh two-byte stream
      clear_counts();
      load_stream(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 16);
      feed(8);
      do_start(16);
      c = 0;
      while (pop_cnt < 5 && c < 100) begin
         tick();
         c++;
      end
      check("t5_reached_5_pops", 64'(pop_cnt >= 5), 64'd1);
      rst = 1'b1;
      tick();
      check("t5_rst_fi_rd", 64'(fi_rd), 64'd0);
      check("t5_rst_valid", 64'(stream_valid), 64'd0);
      check("t5_rst_empty", 64'(stream_empty), 64'd0);
      check("t5_rst_left", 64'(dut.u_buf.left_q), 64'd0);
      rst = 1'b0;
      exp_bits.delete();
      pend_q.delete();
      clear_counts();
      tick(5);
      check("t5_no_pop_after_rst", 64'(pop_cnt), 64'd0);
      fifo_q.delete();
      refresh();
      load_stream({16'hBEEF, 112'h0}, 2);
      feed(1);
      do_start(2);
      check("t5_empty_after_start", 64'(stream_empty), 64'd0);
      wait_valid(50);
      check("t5_first_window", 64'(stream_data), 64'h17DD);
      wait_done(1, 100);
      check("t5_pops", 64'(pop_cnt), 64'd1);

      // Clock-enable freeze mid-run with ack held
      clear_counts();
      load_stream(128'h13579BDF2468ACE00F1E2D3C4B5A6978, 16);
      feed(8);
      stream_ack = 1'b1; stream_width = 4'd7;
      do_start(16);
      tick(8);
      ce_decode  = 1'b0;
      freeze_chk = 1'b1;
      tick(4);
      freeze_chk = 1'b0;
      ce_decode  = 1'b1;
      wait_done(1, 300);
      check("t6_pops", 64'(pop_cnt), 64'd8);
      check("t6_bits_left", 64'(exp_bits.size()), 64'd0);

      // Zero-length stream
      clear_counts();
      do_start(0);
      wait_done(1, 50);
      check("t7_no_valid", 64'(valid_cnt), 64'd0);
      check("t7_no_pop", 64'(pop_cnt), 64'd0);
      tick();
      check("t7_empty", 64'(stream_empty), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
